// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: queue entry layout and pointer sizing.
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 32;
  localparam int unsigned FETCH_DEPTH = 4;
  localparam int unsigned PTR_W       = $clog2(FETCH_DEPTH) + 1;

  typedef logic [FETCH_WIDTH-1:0] word_t;
  typedef logic [PTR_W-1:0]       ptr_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  misaligned;
    logic  filled;
  } fetch_entry_t;

  function automatic logic is_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response port plus the decode valid/ready port of the fetch stage.
interface instr_fetch_if #(
  parameter int unsigned WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc;
  logic             if_misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc, if_misaligned,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc, if_misaligned,
    output if_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated on issue, filled by in-order responses
// and popped by decode. Flush collapses all three pointers onto the allocation pointer.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         alloc_i,
  input  word_t        alloc_pc_i,
  input  logic         fill_i,
  input  word_t        fill_instr_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output ptr_t         used_o,
  output ptr_t         inflight_o,
  output fetch_entry_t head_o
);

  localparam int unsigned IDX_W = PTR_W - 1;

  ptr_t alloc_q;
  ptr_t fill_q;
  ptr_t head_q;

  logic [DEPTH-1:0] filled_q;
  word_t            pc_q    [DEPTH];
  word_t            instr_q [DEPTH];
  logic [DEPTH-1:0] mis_q;

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] head_idx;

  assign alloc_idx = alloc_q[IDX_W-1:0];
  assign fill_idx  = fill_q[IDX_W-1:0];
  assign head_idx  = head_q[IDX_W-1:0];

  assign used_o     = alloc_q - head_q;
  assign inflight_o = alloc_q - fill_q;

  always_comb begin
    head_o            = '0;
    head_o.pc         = pc_q[head_idx];
    head_o.instr      = instr_q[head_idx];
    head_o.misaligned = mis_q[head_idx];
    head_o.filled     = filled_q[head_idx];
  end

  // Only control state is reset; payload is qualified by the filled bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      filled_q <= '0;
    end else if (flush_i) begin
      fill_q <= alloc_q;
      head_q <= alloc_q;
    end else begin
      if (alloc_i) begin
        alloc_q             <= alloc_q + ptr_t'(1);
        filled_q[alloc_idx] <= 1'b0;
      end
      if (fill_i) begin
        fill_q             <= fill_q + ptr_t'(1);
        filled_q[fill_idx] <= 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_i && !flush_i) begin
      pc_q[alloc_idx]  <= alloc_pc_i;
      mis_q[alloc_idx] <= is_misaligned(alloc_pc_i);
    end
    if (fill_i && !flush_i) begin
      instr_q[fill_idx] <= fill_instr_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage top: issues the PC to instruction memory, tracks stale responses
// after a branch flush and presents queued instructions to decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_WIDTH,
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_stall,
  input  logic             flush,
  instr_fetch_if.master    fbus
);

  ptr_t         used;
  ptr_t         inflight;
  fetch_entry_t head;
  logic         below_full;
  logic         fire;
  logic         fill;
  logic         pop;

  ptr_t         drop_cnt_q;
  ptr_t         drop_cnt_d;
  word_t        instr_hold_q;
  word_t        pc_hold_q;
  logic         mis_hold_q;

  assign below_full     = used < ptr_t'(DEPTH);
  assign fbus.imem_req  = !flush && below_full;
  assign fbus.imem_addr = pc;
  assign fire           = fbus.imem_req && fbus.imem_gnt;
  assign pc_stall       = !fire && !flush;

  // Responses owed to flushed fetches are consumed before any new fill.
  assign fill = fbus.imem_rvalid && !flush && (drop_cnt_q == '0);

  assign fbus.if_valid = !flush && (used != '0) && head.filled;
  assign pop           = fbus.if_valid && fbus.if_ready;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc_i      (fire),
    .alloc_pc_i   (pc),
    .fill_i       (fill),
    .fill_instr_i (fbus.imem_rdata),
    .pop_i        (pop),
    .flush_i      (flush),
    .used_o       (used),
    .inflight_o   (inflight),
    .head_o       (head)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = drop_cnt_q + inflight - ptr_t'(fbus.imem_rvalid);
    end else if (fbus.imem_rvalid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - ptr_t'(1);
    end
  end

  // Decode outputs track the head entry while valid and otherwise hold the last shown word.
  assign fbus.if_instr      = fbus.if_valid ? head.instr      : instr_hold_q;
  assign fbus.if_pc         = fbus.if_valid ? head.pc         : pc_hold_q;
  assign fbus.if_misaligned = fbus.if_valid ? head.misaligned : mis_hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q   <= '0;
      instr_hold_q <= '0;
      pc_hold_q    <= '0;
      mis_hold_q   <= 1'b0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      instr_hold_q <= fbus.if_instr;
      pc_hold_q    <= fbus.if_pc;
      mis_hold_q   <= fbus.if_misaligned;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage between the program counter and decode. Each cycle it issues the current PC to instruction memory over a request/grant port and tracks up to DEPTH in-flight or buffered fetches in an in-order queue. It returns completed instructions to decode over a valid/ready handshake. It holds the PC through `pc_stall` when it cannot issue, and discards stale work on a branch flush.

## Interface
- `WIDTH`, 32, address/instruction width
- `DEPTH`, 4, queue entries; power of two, ≥2
- `clk` input 1: rising-edge clock
- `reset_n` input 1: asynchronous, active-low reset
- `pc` input WIDTH: current PC from the program counter
- `pc_stall` output 1: hold the PC this cycle
- `flush` input 1: branch taken this cycle (same signal as the PC's `take_branch`)
- `imem_req` output 1: fetch request valid
- `imem_addr` output WIDTH: fetch address, equal to `pc`
- `imem_gnt` input 1: memory accepts the request this cycle
- `imem_rvalid` input 1: response valid; responses arrive in order, ≥1 cycle after grant
- `imem_rdata` input WIDTH: instruction word
- `if_valid` output 1: instruction available to decode
- `if_ready` input 1: decode accepts
- `if_instr` output WIDTH: instruction
- `if_pc` output WIDTH: PC of `if_instr`
- `if_misaligned` output 1: `if_pc[1:0] != 0`

## Operation
- Queue state:
  - Pointers `alloc_ptr`, `fill_ptr`, `head_ptr` are log2(DEPTH)+1 bits each and wrap naturally.
  - `used = alloc_ptr - head_ptr`.
  - Each entry holds pc, instr, misaligned, and a `filled` bit.
- Issue:
  - `imem_req = !flush && used < DEPTH`.
  - The request fires when `imem_req && imem_gnt`.
  - On fire: write {pc, misaligned} at `alloc_ptr`, clear `filled`, increment `alloc_ptr`.
  - A misaligned PC is still requested. The fault is only tagged.
- `pc_stall = !fire && !flush`. The PC advances exactly once per fire, or loads the branch target on flush.
- Fill:
  - When `imem_rvalid` arrives and `drop_cnt == 0`: write instr at `fill_ptr`, set `filled`, increment `fill_ptr`.
  - When `drop_cnt != 0`: discard the response and decrement `drop_cnt`.
- Drain:
  - `if_valid = used != 0 && entry[head].filled`.
  - When `if_valid && if_ready`: increment `head_ptr`.
  - Outputs come from the head entry (registered, no bypass).
- Flush:
  - On that edge, set `head_ptr`, `fill_ptr` and `alloc_ptr` equal to `alloc_ptr`.
  - `drop_cnt <= drop_cnt + (alloc_ptr - fill_ptr) - (imem_rvalid ? 1 : 0)`. A response in the flush cycle is discarded and counted.
  - No issue and no handshake with decode occur in the flush cycle.
  - `if_valid` is forced to 0 in the flush cycle.
- `drop_cnt` width is log2(DEPTH)+1 bits. It never exceeds DEPTH, because `used < DEPTH` gates issue and dropped slots are freed.

## Timing
- Reset (asynchronous, `reset_n` = 0):
  - Pointers = 0 and `drop_cnt` = 0.
  - Entries' `filled` = 0.
  - `if_valid` = 0.
  - `imem_req` is combinational and becomes 1 once `reset_n` deasserts with `flush` = 0.
- Latency:
  - Fire at cycle N; rvalid at cycle M ≥ N+1; `if_valid` at M+1.
  - Throughput is 1 instruction/cycle when memory grants every cycle and responds at fixed latency ≤ DEPTH−1.
- Full (`used == DEPTH`): `imem_req` = 0 and `pc_stall` = 1 until decode pops. A pop and an issue in the same cycle are both legal.
- Empty or head not filled: `if_valid` = 0, and `if_instr`/`if_pc` hold their previous values.
- Reset deasserted mid-operation: all state returns to reset values. Outstanding memory responses after reset are the memory's responsibility and are not dropped.
- `if_instr`/`if_pc` must remain stable while `if_valid && !if_ready`.

## Structure
- `fetch_pkg`:
  - `fetch_entry_t` {pc, instr, misaligned, filled}.
  - `localparam PTR_W = $clog2(DEPTH)+1`.
- Sub-module `fetch_queue`: entry storage with the three pointers, alloc/fill/pop ports and a flush input. `instr_fetch` holds the issue logic, `drop_cnt` and the handshakes.

## Test plan
- Streaming:
  - Stimulus: reset, `pc` driven by the real `program_counter` starting at 0x0; memory grants every cycle with latency 1.
  - Response: decode receives 0x0, 0x4, 0x8… back-to-back, with `if_valid` first high 2 cycles after reset release.
- Backpressure to full:
  - Stimulus: hold `if_ready` = 0.
  - Response: exactly 4 fires, then `imem_req` = 0 and `pc_stall` = 1 with pc = 0x10.
  - Release: one pop re-enables one issue.
- Flush with in-flight fetches:
  - Stimulus: memory latency 3; assert `flush` with 3 outstanding and `pc` → 0x100.
  - Response: the next 3 rvalids are dropped, and the first `if_pc` delivered is 0x100.
- Flush coincident with rvalid and with decode ready:
  - Response: the response is counted as dropped, no pop occurs, and `drop_cnt` is correct.
- Grant stalls:
  - Stimulus: `imem_gnt` low for 5 cycles.
  - Response: `pc_stall` = 1 and pc is held; no duplicate or skipped PCs afterwards.
- Misaligned PC:
  - Stimulus: `pc` = 0x102.
  - Response: the fetch is issued, and decode sees `if_misaligned` = 1 with `if_pc` = 0x102.
- Asynchronous reset asserted mid-stream:
  - Response: `if_valid` = 0 immediately and the pointers are 0.
